// File: rtl/snes_joypad.sv
// rtl/snes_joypad.sv - SNES serial controller reader producing the Gameboy joystick vector
module snes_joypad #(
    parameter int HALF_CYCLES  = 25,
    parameter int LATCH_CYCLES = 50,
    parameter int POLL_PERIOD  = 69905
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_data,
    output logic        joy_strobe,
    output logic        joy_clock,
    output logic [7:0]  joystick,
    output logic [11:0] snes_buttons,
    output logic        present,
    output logic        update
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX);
    localparam int TW        = ($clog2(POLL_PERIOD) > 0) ? $clog2(POLL_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CLK_LO,
        S_CLK_HI,
        S_UPDATE
    } state_t;

    state_t        state, state_next;
    logic [1:0]    sync;
    logic          data_s;
    logic [TW-1:0] poll_cnt;
    logic          pending;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_val;
    logic          phase_load;
    logic          phase_done;
    logic [3:0]    bit_idx;
    logic [15:0]   cap;
    logic          sample;
    logic          last_bit;
    logic          scan_start;
    logic [15:0]   raw_next;
    logic [15:0]   pressed;
    logic          valid;
    logic          lr_both;
    logic          ud_both;

    assign data_s     = sync[1];
    assign phase_done = (phase == '0);

    // Two-flop synchronizer; idles at the released level so reset never looks like a press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], joy_data};
        end
    end

    // Free-running poll timer; ticks arriving during a scan collapse into one pending request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
            pending  <= 1'b0;
        end else if (poll_cnt == '0) begin
            poll_cnt <= TW'(POLL_PERIOD - 1);
            pending  <= 1'b1;
        end else begin
            poll_cnt <= poll_cnt - 1'b1;
            if (scan_start) begin
                pending <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, phase control and controller line drive
    always_comb begin
        state_next = state;
        phase_load = 1'b0;
        phase_val  = '0;
        sample     = 1'b0;
        last_bit   = 1'b0;
        scan_start = 1'b0;
        joy_strobe = 1'b0;
        joy_clock  = 1'b1;
        update     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    scan_start = 1'b1;
                    phase_load = 1'b1;
                    phase_val  = PW'(LATCH_CYCLES - 1);
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                joy_strobe = 1'b1;
                if (phase_done) begin
                    sample     = 1'b1;
                    phase_load = 1'b1;
                    phase_val  = PW'(HALF_CYCLES - 1);
                    state_next = S_CLK_LO;
                end
            end
            S_CLK_LO: begin
                joy_clock = 1'b0;
                if (phase_done) begin
                    phase_load = 1'b1;
                    phase_val  = PW'(HALF_CYCLES - 1);
                    state_next = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (phase_done) begin
                    sample = 1'b1;
                    if (bit_idx == 4'd15) begin
                        last_bit   = 1'b1;
                        state_next = S_UPDATE;
                    end else begin
                        phase_load = 1'b1;
                        phase_val  = PW'(HALF_CYCLES - 1);
                        state_next = S_CLK_LO;
                    end
                end
            end
            S_UPDATE: begin
                update     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Phase timer, bit index and capture shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            bit_idx <= '0;
            cap     <= '0;
        end else begin
            if (phase_load) begin
                phase <= phase_val;
            end else if (!phase_done) begin
                phase <= phase - 1'b1;
            end
            if (scan_start) begin
                bit_idx <= '0;
            end else if (sample) begin
                cap[bit_idx] <= data_s;
                bit_idx      <= bit_idx + 1'b1;
            end
        end
    end

    // Final bit is folded in directly so results publish on the edge entering UPDATE
    always_comb begin
        raw_next = {data_s, cap[14:0]};
        pressed  = ~raw_next;
        valid    = ~|pressed[15:12];
        lr_both  = pressed[6] & pressed[7];
        ud_both  = pressed[4] & pressed[5];
    end

    // Publish decoded buttons; a bad signature clears everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joystick     <= '0;
            snes_buttons <= '0;
            present      <= 1'b0;
        end else if (last_bit) begin
            if (valid) begin
                snes_buttons <= pressed[11:0];
                present      <= 1'b1;
                joystick     <= {pressed[3],
                                 pressed[2],
                                 pressed[0] | pressed[1],
                                 pressed[8] | pressed[9],
                                 pressed[5] & ~ud_both,
                                 pressed[4] & ~ud_both,
                                 pressed[6] & ~lr_both,
                                 pressed[7] & ~lr_both};
            end else begin
                snes_buttons <= '0;
                present      <= 1'b0;
                joystick     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_snes_joypad.sv
// tb/tb_snes_joypad.sv - table-driven bench for snes_joypad with a shift-register controller model
module tb_snes_joypad;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_data;
    logic        joy_strobe;
    logic        joy_clock;
    logic [7:0]  joystick;
    logic [11:0] snes_buttons;
    logic        present;
    logic        update;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snes_joypad #(
        .HALF_CYCLES (25),
        .LATCH_CYCLES(50),
        .POLL_PERIOD (100)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .joy_data    (joy_data),
        .joy_strobe  (joy_strobe),
        .joy_clock   (joy_clock),
        .joystick    (joystick),
        .snes_buttons(snes_buttons),
        .present     (present),
        .update      (update)
    );

    // Controller model: raw word is active-low, bit 0 presented first, shifts on rising joy_clock
    logic [15:0] word = 16'hFFFF;
    logic [15:0] sh = 16'hFFFF;
    logic        prev_jc = 1'b1;
    logic        tie_en = 1'b0;
    logic        tie_val = 1'b1;

    always @(posedge clk) begin
        prev_jc <= joy_clock;
        if (joy_strobe)
            sh <= word;
        else if (joy_clock && !prev_jc)
            sh <= {1'b1, sh[15:1]};
    end

    assign joy_data = tie_en ? tie_val : sh[0];

    typedef struct {
        logic [15:0] pressed;
        logic        t_en;
        logic        t_val;
        logic [11:0] snes;
        logic [7:0]  joy;
        logic        pres;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_update(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 2000 && !ok) begin
            tick();
            n++;
            if (update) ok = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_strobe"}, joy_strobe, 1'b0);
        check({tag, "_clock"}, joy_clock, 1'b1);
        check({tag, "_joystick"}, joystick, 8'h00);
        check({tag, "_snes"}, snes_buttons, 12'h000);
        check({tag, "_present"}, present, 1'b0);
        check({tag, "_update"}, update, 1'b0);
    endtask

    initial begin
        int  n;
        bit  ok;
        int  hi, lo_total, falls, overlap, upd_at, upd_cnt;
        logic prev;

        vt[0] = '{16'h0108, 1'b0, 1'b0, 12'h108, 8'h90, 1'b1};
        vt[1] = '{16'h0000, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0};
        vt[2] = '{16'h0000, 1'b1, 1'b1, 12'h000, 8'h00, 1'b1};
        vt[3] = '{16'h00D0, 1'b0, 1'b0, 12'h0D0, 8'h04, 1'b1};
        vt[4] = '{16'h0031, 1'b0, 1'b0, 12'h031, 8'h20, 1'b1};
        vt[5] = '{16'h0286, 1'b0, 1'b0, 12'h286, 8'h71, 1'b1};
        vt[6] = '{16'h0FFF, 1'b0, 1'b0, 12'hFFF, 8'hF0, 1'b1};
        vt[7] = '{16'h8108, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0};
        vt[8] = '{16'h0C00, 1'b0, 1'b0, 12'hC00, 8'h00, 1'b1};
        vt[9] = '{16'h0108, 1'b0, 1'b0, 12'h108, 8'h90, 1'b1};

        // Reset state
        repeat (3) tick();
        check_reset_values("reset");

        // Release: strobe rises on the second edge
        reset_n = 1'b1;
        n = 0;
        while (!joy_strobe && n < 10) begin
            tick();
            n++;
        end
        check("strobe_delay", n, 2);

        // First scan shape, measured from the strobe-rise cycle (offset 0)
        hi = 1; lo_total = 0; falls = 0; overlap = 0; upd_at = 0;
        prev = joy_clock;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (joy_strobe) hi++;
            if (!joy_clock) lo_total++;
            if (!joy_clock && joy_strobe) overlap++;
            if (prev && !joy_clock) falls++;
            prev = joy_clock;
            if (update) begin
                upd_at = i;
                break;
            end
        end
        check("strobe_len", hi, 50);
        check("clock_falls", falls, 15);
        check("clock_low_cycles", lo_total, 375);
        check("clock_during_strobe", overlap, 0);
        check("update_offset", upd_at, 800);
        check("idle_present", present, 1'b1);
        check("idle_joystick", joystick, 8'h00);
        check("idle_snes", snes_buttons, 12'h000);

        // Vector table: each entry is applied for exactly one back-to-back scan
        for (int v = 0; v < 10; v++) begin
            word    = ~vt[v].pressed;
            tie_en  = vt[v].t_en;
            tie_val = vt[v].t_val;
            wait_update(n, ok);
            check($sformatf("vec%0d_timeout", v), ok, 1'b1);
            check($sformatf("vec%0d_spacing", v), n, 802);
            check($sformatf("vec%0d_snes", v), snes_buttons, vt[v].snes);
            check($sformatf("vec%0d_joystick", v), joystick, vt[v].joy);
            check($sformatf("vec%0d_present", v), present, vt[v].pres);
        end

        // Back-to-back strobe spacing and update count between rises
        n = 0;
        while (!joy_strobe && n < 2000) begin
            tick();
            n++;
        end
        check("b2b_first_rise", joy_strobe, 1'b1);
        n = 0; upd_cnt = 0;
        while (joy_strobe && n < 2000) begin
            tick();
            n++;
        end
        while (!joy_strobe && n < 2000) begin
            tick();
            n++;
            if (update) upd_cnt++;
        end
        check("b2b_strobe_period", n, 802);
        check("b2b_update_count", upd_cnt, 1);

        // Reset mid-scan during CLK_HI of bit 7 (offsets 375..399 after strobe rise)
        repeat (385) tick();
        check("mid_in_clk_hi", {joy_strobe, joy_clock}, 2'b01);
        check("mid_pre_joystick", joystick, 8'h90);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        check_reset_values("midreset_held");
        reset_n = 1'b1;
        wait_update(n, ok);
        check("restart_timeout", ok, 1'b1);
        check("restart_latency", n, 802);
        check("restart_snes", snes_buttons, 12'h108);
        check("restart_joystick", joystick, 8'h90);
        check("restart_present", present, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
